crc_frame_tx: RTL

//  Downstream consumer of the crc16 engine. On a send trigger it starts crc16 over the

---
 rtl/crc_frame_tx_pkg.sv | 30 +++
 rtl/crc_frame_tx_if.sv | 9 +
 rtl/crc_frame_tx_fifo.sv | 51 +++++
 rtl/crc_frame_tx.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/crc_frame_tx_pkg.sv
// Shared types and constants for the CRC-framed byte transmitter.
// Frame layout: SOF, LEN_HI, LEN_LO, payload, CRC_HI, CRC_LO.
package crc_frame_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CRC_WAIT = 3'd1,
    ST_HDR      = 3'd2,
    ST_PAYLOAD  = 3'd3,
    ST_TRAILER  = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  localparam logic [7:0] SOF_BYTE_DEF   = 8'h7E;
  localparam int         HDR_BYTES      = 3;
  localparam int         TRL_BYTES      = 2;
  localparam int         FRAME_OVERHEAD = HDR_BYTES + TRL_BYTES;

  // Header byte by position: 0 = SOF, 1 = length high, 2 = length low.
  function automatic logic [7:0] hdr_byte(input logic [1:0]  idx,
                                          input logic [15:0] len,
                                          input logic [7:0]  sof);
    case (idx)
      2'd0:    hdr_byte = sof;
      2'd1:    hdr_byte = len[15:8];
      default: hdr_byte = len[7:0];
    endcase
  endfunction

endpackage

// File: rtl/crc_frame_tx_if.sv
// Byte stream valid/ready interface carrying the framed packet to its sink.
interface crc_frame_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input  tx_ready);
  modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/crc_frame_tx_fifo.sv
// Small first-word-fall-through FIFO used as the output skid buffer.
// The head word is visible on dout while not empty; dout reads 0 when empty.
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             wr_en;
  logic             rd_en;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign count = wr_ptr_reg - rd_ptr_reg;
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign dout  = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge i_Clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/crc_frame_tx.sv
// Frames a BRAM-resident payload as SOF/LEN/payload/CRC on a byte stream,
// after obtaining the payload CRC from the external crc16 engine.
module crc_frame_tx
  import crc_frame_tx_pkg::*;
#(
  parameter int         ADDR_W   = 9,
  parameter int         BRAM_LAT = 2,
  parameter int         FIFO_D   = 4,
  parameter logic [7:0] SOF_BYTE = SOF_BYTE_DEF
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic              i_send_trig,
  input  logic [ADDR_W-1:0] i_data_len,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_len_err,
  output logic              o_crc_start,
  input  logic              i_crc_ready,
  input  logic [15:0]       i_crc_value,
  output logic [ADDR_W-1:0] o_bram_addr,
  output logic              o_bram_en,
  input  logic [7:0]        i_bram_dout,
  crc_frame_tx_if.master    tx
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int FAW   = $clog2(FIFO_D);
  localparam int FCW   = FAW + 1;

  state_t            state_reg;
  state_t            state_next;
  logic [ADDR_W-1:0] len_reg;
  logic [15:0]       crc_reg;
  logic              crc_first_reg;
  logic [1:0]        hdr_cnt_reg;
  logic              trl_cnt_reg;
  logic [CNT_W-1:0]  rd_cnt_reg;
  logic [CNT_W-1:0]  push_cnt_reg;
  logic [FCW-1:0]    inflight_reg;
  logic [BRAM_LAT-1:0] rd_vld_reg;

  logic              fifo_push;
  logic              fifo_pop;
  logic [7:0]        fifo_din;
  logic [7:0]        fifo_dout;
  logic              fifo_empty;
  logic              fifo_full;
  logic [FCW-1:0]    fifo_count;

  logic              trig_ok;
  logic              trig_bad;
  logic              rd_ret;
  logic              rd_issue;
  logic              hdr_push;
  logic              trl_push;
  logic              pay_last;
  logic              crc_take;
  logic [CNT_W-1:0]  len_ext;
  logic [FCW:0]      credit_sum;

  assign trig_ok  = i_send_trig && (i_data_len != '0);
  assign trig_bad = i_send_trig && (i_data_len == '0);
  assign len_ext  = {1'b0, len_reg};
  assign rd_ret   = rd_vld_reg[BRAM_LAT-1];
  assign crc_take = (state_reg == ST_CRC_WAIT) && !crc_first_reg && i_crc_ready;
  assign hdr_push = (state_reg == ST_HDR) && !fifo_full;
  assign trl_push = (state_reg == ST_TRAILER) && !fifo_full;
  assign pay_last = (state_reg == ST_PAYLOAD) && rd_ret &&
                    ((push_cnt_reg + CNT_W'(1)) == len_ext);

  // Reads are only issued when a FIFO slot is reserved for every outstanding
  // return, so the BRAM pipeline can never overrun a stalled sink.
  assign credit_sum = {1'b0, fifo_count} + {1'b0, inflight_reg};
  assign rd_issue   = (state_reg == ST_PAYLOAD) && (rd_cnt_reg < len_ext) &&
                      (credit_sum < (FCW+1)'(FIFO_D));

  assign fifo_pop    = tx.tx_valid && tx.tx_ready;
  assign tx.tx_valid = !fifo_empty;
  assign tx.tx_data  = fifo_dout;

  sync_fifo_fwft #(
    .WIDTH (8),
    .DEPTH (FIFO_D)
  ) u_fifo (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .push    (fifo_push),
    .din     (fifo_din),
    .pop     (fifo_pop),
    .dout    (fifo_dout),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:     if (trig_ok) state_next = ST_CRC_WAIT;
      ST_CRC_WAIT: if (crc_take) state_next = ST_HDR;
      ST_HDR:      if (hdr_push && (hdr_cnt_reg == 2'(HDR_BYTES-1))) state_next = ST_PAYLOAD;
      ST_PAYLOAD:  if (pay_last) state_next = ST_TRAILER;
      ST_TRAILER:  if (trl_push && trl_cnt_reg) state_next = ST_DONE;
      ST_DONE:     if (fifo_empty) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy      = (state_reg != ST_IDLE);
    o_done      = (state_reg == ST_DONE) && fifo_empty;
    o_crc_start = (state_reg == ST_IDLE) && trig_ok;
    o_len_err   = (state_reg == ST_IDLE) && trig_bad;
    o_bram_en   = rd_issue;
    o_bram_addr = rd_issue ? rd_cnt_reg[ADDR_W-1:0] : '0;
    fifo_push   = 1'b0;
    fifo_din    = '0;
    case (state_reg)
      ST_HDR: begin
        fifo_push = hdr_push;
        fifo_din  = hdr_byte(hdr_cnt_reg, 16'(len_reg), SOF_BYTE);
      end
      ST_PAYLOAD: begin
        fifo_push = rd_ret;
        fifo_din  = i_bram_dout;
      end
      ST_TRAILER: begin
        fifo_push = trl_push;
        fifo_din  = trl_cnt_reg ? crc_reg[7:0] : crc_reg[15:8];
      end
      default: begin
        fifo_push = 1'b0;
        fifo_din  = '0;
      end
    endcase
  end

  // crc16 drops its ready flag one cycle late, so the first CRC_WAIT cycle
  // may still show the previous frame's result and is skipped.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      len_reg       <= '0;
      crc_reg       <= '0;
      crc_first_reg <= 1'b0;
      hdr_cnt_reg   <= '0;
      trl_cnt_reg   <= 1'b0;
      rd_cnt_reg    <= '0;
      push_cnt_reg  <= '0;
      inflight_reg  <= '0;
    end else begin
      crc_first_reg <= (state_reg == ST_IDLE) && trig_ok;
      if ((state_reg == ST_IDLE) && trig_ok) begin
        len_reg      <= i_data_len;
        hdr_cnt_reg  <= '0;
        trl_cnt_reg  <= 1'b0;
        rd_cnt_reg   <= '0;
        push_cnt_reg <= '0;
      end
      if (crc_take) crc_reg <= i_crc_value;
      if (hdr_push) hdr_cnt_reg <= hdr_cnt_reg + 2'd1;
      if (trl_push) trl_cnt_reg <= !trl_cnt_reg;
      if (rd_issue) rd_cnt_reg <= rd_cnt_reg + CNT_W'(1);
      if ((state_reg == ST_PAYLOAD) && rd_ret) push_cnt_reg <= push_cnt_reg + CNT_W'(1);
      case ({rd_issue, rd_ret})
        2'b10:   inflight_reg <= inflight_reg + FCW'(1);
        2'b01:   inflight_reg <= inflight_reg - FCW'(1);
        default: inflight_reg <= inflight_reg;
      endcase
    end
  end

  // Read-valid delay line: bit BRAM_LAT-1 marks the cycle the data is on i_bram_dout.
  generate
    for (genvar gi = 0; gi < BRAM_LAT; gi++) begin : g_rd_vld
      always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
          rd_vld_reg[gi] <= 1'b0;
        end else if (gi == 0) begin
          rd_vld_reg[gi] <= rd_issue;
        end else begin
          rd_vld_reg[gi] <= rd_vld_reg[(gi == 0) ? 0 : gi-1];
        end
      end
    end
  endgenerate

endmodule
